// File: rtl/bcd_to_bin_seq.sv
// Sequential three-digit BCD to binary converter.
// A valid request is converted by ten reverse double-dabble steps, one per clock.
// A request holding any digit above 9 is rejected at once with an all-ones result and err set.
//
// state | meaning
// IDLE  | waiting for start; the next request is captured here
// CONV  | one shift/correct step per cycle, ten steps in total
// DONE  | single-cycle completion pulse, then back to IDLE
module bcd_to_bin_seq #(
  parameter int DELAY = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] bcd_in,
  output logic [9:0]  bin_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // DELAY is a simulation-only output delay with no functional effect.
  // The RTL is zero-delay, so only the range check below uses it.
  if (DELAY < 0) begin : g_neg_delay
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'd9;

  state_t      state_q, state_d;
  logic [21:0] work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  bin_q, bin_d;
  logic        err_q, err_d;
  logic        digit_bad;
  logic [21:0] work_step;

  // One step: shift the whole register right, then pull any BCD field that
  // reached 8 or more back down by 3.
  function automatic logic [21:0] dd_step(input logic [21:0] w);
    logic [21:0] s;
    s = {1'b0, w[21:1]};
    if (s[21:18] >= 4'd8) s[21:18] = s[21:18] - 4'd3;
    if (s[17:14] >= 4'd8) s[17:14] = s[17:14] - 4'd3;
    if (s[13:10] >= 4'd8) s[13:10] = s[13:10] - 4'd3;
    return s;
  endfunction

  // Flag a request that holds any digit above 9, and form the next step.
  always_comb begin
    digit_bad = (bcd_in[11:8] > 4'd9) || (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);
    work_step = dd_step(work_q);
  end

  // Next-state and datapath update for the capture / convert / done sequence.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (digit_bad) begin
            err_d   = 1'b1;
            bin_d   = 10'h3FF;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            work_d  = {bcd_in, 10'b0};
            cnt_d   = 4'd0;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        work_d = work_step;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST_STEP) begin
          bin_d   = work_step[9:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, including a partial result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      work_q  <= 22'd0;
      cnt_q   <= 4'd0;
      bin_q   <= 10'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign busy    = (state_q == S_CONV);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: a timeline model predicts every output each cycle,
// directed scenarios pin literal results, and random stimulus exercises the rest.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] bcd_in;
  logic [9:0]  bin_out;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;
  int cyc      = 0;

  bcd_to_bin_seq #(.DELAY(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bcd_in (bcd_in),
    .bin_out(bin_out),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: a request either fails at once or lands ten cycles later
  // with the decimal value of its digits.
  bit        m_busy = 0;
  bit        m_done = 0;
  bit        m_err  = 0;
  logic [9:0] m_bin = 10'd0;
  int        m_left = 0;
  int        m_val  = 0;

  function automatic bit bcd_bad(input logic [11:0] b);
    return (b[11:8] > 9) || (b[7:4] > 9) || (b[3:0] > 9);
  endfunction

  function automatic int bcd_val(input logic [11:0] b);
    return 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_err = 0; m_bin = 10'd0; m_left = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
        m_bin  = 10'(m_val);
      end
    end else if (start) begin
      if (bcd_bad(bcd_in)) begin
        m_err  = 1;
        m_done = 1;
        m_bin  = 10'h3FF;
      end else begin
        m_err  = 0;
        m_busy = 1;
        m_left = 10;
        m_val  = bcd_val(bcd_in);
      end
    end
  end

  // Compare DUT against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("bin_out", 32'(bin_out), 32'(m_bin));
      chk("busy_and_done", 32'(busy & done), 32'd0);
    end
  end

  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic wait_done(input int lim, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < lim);
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for done after %0d cycles", nm, lim);
    end
  endtask

  task automatic do_conv(input logic [11:0] b, input logic [9:0] exp_bin,
                         input bit exp_err, input string nm);
    int d0;
    start  = 1'b1;
    bcd_in = b;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = $urandom_range(0, 4095);
    d0 = done_cnt;
    if (done !== 1'b1) wait_done(20, nm);
    chk({nm, "_bin"}, 32'(bin_out), 32'(exp_bin));
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    chk({nm, "_one_done"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int lat;
    int last;
    reset  = 1'b1;
    start  = 1'b1;
    bcd_in = 12'h123;
    repeat (2) @(negedge clk);
    cmp_en = 1;
    chk("reset_bin", 32'(bin_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    // 999: busy for ten cycles, then done.
    start  = 1'b1;
    bcd_in = 12'h999;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (busy === 1'b1 && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    chk("s999_busy_cycles", 32'(lat), 32'd10);
    chk("s999_done", 32'(done), 32'd1);
    chk("s999_bin", 32'(bin_out), 32'd999);
    chk("model_999", 32'(m_bin), 32'h3E7);
    @(negedge clk);

    do_conv(12'h000, 10'd0, 1'b0, "s000");
    do_conv(12'h512, 10'd512, 1'b0, "s512");
    do_conv(12'h1A3, 10'h3FF, 1'b1, "s1A3");
    do_conv(12'h042, 10'd42, 1'b0, "s042");

    // Second start while converting must be ignored.
    start  = 1'b1;
    bcd_in = 12'h250;
    @(negedge clk);
    start = 1'b0;
    last  = done_cnt;
    repeat (3) @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h777;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, "s250");
    chk("s250_bin", 32'(bin_out), 32'd250);
    repeat (15) @(negedge clk);
    chk("s250_single_done", 32'(done_cnt - last), 32'd1);

    // Mid-conversion reset discards the result.
    start  = 1'b1;
    bcd_in = 12'h638;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    last  = done_cnt;
    @(negedge clk);
    chk("s638_rst_bin", 32'(bin_out), 32'd0);
    chk("s638_rst_busy", 32'(busy), 32'd0);
    chk("s638_rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("s638_no_done", 32'(done_cnt - last), 32'd0);
    do_conv(12'h638, 10'd638, 1'b0, "s638");

    // Random stimulus, occasional resets and bad digits.
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 2) != 0);
      bcd_in = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095))
                                           : to_bcd($urandom_range(0, 999));
      reset  = ($urandom_range(0, 150) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (15) @(negedge clk);

    // Exhaustive sweep with start held high: period 12 between done pulses.
    start  = 1'b1;
    bcd_in = to_bcd(0);
    last   = -1;
    for (int v = 0; v < 1000; v++) begin
      wait_done(20, "sweep");
      chk("sweep_bin", 32'(bin_out), 32'(v));
      if (last >= 0) chk("sweep_period", 32'(cyc - last), 32'd12);
      last   = cyc;
      bcd_in = to_bcd((v + 1) % 1000);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
BCD_TO_BIN_SEQ -- requirements
Module: bcd_to_bin_seq

Interface
REQ-001 Parameter DELAY, default 10, propagation delay (ns) applied to every output assignment; simulation only, no functional effect.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 bcd_in  input  12  three packed BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 bin_out  output  10  binary result, 0..999, registered, held between conversions.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  single-cycle completion pulse.
REQ-009 err  output  1  high when the last accepted request held a digit greater than 9.

Function
REQ-010 The block SHALL implement states IDLE, CONV and DONE, with IDLE as the reset state.
REQ-011 In IDLE with start=1 at edge k, the block SHALL capture bcd_in, clear err, and check every digit.
REQ-012 Valid capture SHALL load a 22-bit working register {bcd[11:0], bin[9:0]} = {bcd_in, 10'b0}, clear the 4-bit iteration counter, and go to CONV with busy=1 from edge k.
REQ-013 Invalid capture, any digit > 9, SHALL go directly to DONE at edge k with bin_out=10'h3FF and err=1, and SHALL NOT enter CONV.
REQ-014 Each CONV cycle SHALL perform one reverse double-dabble step in one clock.
REQ-015 The step SHALL logically right-shift the whole 22-bit register by one, shifting 0 into bit 21.
REQ-016 After the shift, the step SHALL subtract 3 from each 4-bit BCD field whose shifted value is >= 8.
REQ-017 CONV SHALL execute exactly 10 steps, at edges k+1..k+10.
REQ-018 At edge k+10 the block SHALL load bin_out with bin[9:0], drop busy, and enter DONE.
REQ-019 done SHALL be 1 for exactly one cycle, during the DONE state only; the next edge SHALL return to IDLE.
REQ-020 Latency, valid input: done high in the cycle after edge k+10; invalid input: done high in the cycle after edge k.
REQ-021 start in CONV or DONE SHALL be ignored: no capture, no restart, and no effect on the in-flight result.
REQ-022 start held high continuously SHALL start a new conversion at the first IDLE edge after each DONE, giving a back-to-back period of 12 cycles.
REQ-023 bin_out SHALL change only at the edge entering DONE; bcd_in changes after capture SHALL have no effect.
REQ-024 err SHALL hold its value until the next accepted start or reset.
REQ-025 busy and done SHALL never be high in the same cycle.

Reset
REQ-026 reset=1 at any edge SHALL force IDLE, bin_out=0, busy=0, done=0, err=0, working register=0 and counter=0.
REQ-027 Reset SHALL take priority over start and over any in-flight conversion; a mid-conversion reset discards the partial result.
REQ-028 With reset held high the block SHALL ignore start.

Verification
REQ-029 Scenario: start with bcd_in=12'h999 -> busy high for 10 cycles, then done pulse with bin_out=10'd999 (0x3E7), err=0.
REQ-030 Scenario: start with bcd_in=12'h000, then a second start with 12'h512 -> bin_out=0, then bin_out=10'd512; each done exactly 1 cycle wide.
REQ-031 Scenario: start with bcd_in=12'h1A3 -> done in the next cycle, bin_out=10'h3FF, err=1, busy never high; a following start with 12'h042 -> err=0, bin_out=10'd42.
REQ-032 Scenario: start with 12'h250, then start pulsed again 4 cycles later with bcd_in=12'h777 -> second pulse ignored, bin_out=10'd250, single done.
REQ-033 Scenario: start with 12'h638, reset asserted 5 cycles later -> all outputs 0 at the next edge, no done pulse; a following start with 12'h638 -> bin_out=10'd638.
REQ-034 Scenario: exhaustive sweep of bcd_in over all 1000 valid codes with start held high -> bin_out equals the decimal value each time, done period 12 cycles.
